// File: rtl/r408_pkg.sv
// r408_pkg: shared FSM state type and constants for the r408 data-bus bridge
package r408_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  localparam int TMO_W_DEF = 8;
  localparam logic [7:0] RD_ERR_DATA = 8'hFF;
endpackage

// File: rtl/r408_wbuf.sv
// r408_wbuf: one-entry posted write buffer with capture handshake and read-forward compare
// Ports: clk, rst (sync, active-high); waddr/wdata/write from core; drain empties the entry;
// raddr is compared for forwarding; valid/addr/data expose the entry; wrdy is the accept pulse; hit flags a forward match.
module r408_wbuf import r408_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] waddr,
  input  logic [7:0]  wdata,
  input  logic        write,
  input  logic        drain,
  input  logic [23:0] raddr,
  output logic        valid,
  output logic [23:0] addr,
  output logic [7:0]  data,
  output logic        wrdy,
  output logic        hit
);
  logic cap;
  // wrdy gates a second capture while the core still holds write in the pulse cycle
  assign cap = write && !valid && !wrdy;
  assign hit = valid && addr == raddr;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      wrdy  <= 1'b0;
    end else begin
      wrdy <= cap;
      if (cap) begin
        valid <= 1'b1;
        addr  <= waddr;
        data  <= wdata;
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/r408_dbus_bridge.sv
// r408_dbus_bridge: core-to-memory bridge with posted write buffer, read forwarding and bus timeout
// Ports: clk, rst (sync, active-high); core read side raddr/read/rdata/rrdy; core write side waddr/wdata/write/wrdy;
// memory side m_req/m_we/m_addr/m_wdata/m_rdata/m_ack; err_clr clears the sticky bus_err timeout flag.
module r408_dbus_bridge import r408_pkg::*; #(
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] raddr,
  input  logic        read,
  output logic [7:0]  rdata,
  output logic        rrdy,
  input  logic [23:0] waddr,
  input  logic [7:0]  wdata,
  input  logic        write,
  output logic        wrdy,
  output logic        m_req,
  output logic        m_we,
  output logic [23:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic        m_ack,
  input  logic        err_clr,
  output logic        bus_err
);
  // last count value before the counter would reach all-ones, so m_req stays up 2^TMO_W-1 cycles
  localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);
  state_t state;
  logic [TMO_W-1:0] cnt;
  logic wb_valid, wb_hit, req_rd, tmo, drain;
  logic [23:0] wb_addr;
  logic [7:0] wb_data;
  assign req_rd = read && !rrdy;
  assign tmo    = m_req && !m_ack && cnt == TMO_LAST;
  assign drain  = state == WR && (m_ack || tmo);
  r408_wbuf u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .waddr (waddr),
    .wdata (wdata),
    .write (write),
    .drain (drain),
    .raddr (raddr),
    .valid (wb_valid),
    .addr  (wb_addr),
    .data  (wb_data),
    .wrdy  (wrdy),
    .hit   (wb_hit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rrdy    <= 1'b0;
      rdata   <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      bus_err <= 1'b0;
    end else begin
      rrdy    <= 1'b0;
      bus_err <= tmo || (bus_err && !err_clr);
      case (state)
        IDLE: begin
          if (req_rd && wb_hit) begin
            rdata <= wb_data;
            rrdy  <= 1'b1;
          end else if (wb_valid) begin
            state   <= WR;
            m_req   <= 1'b1;
            m_we    <= 1'b1;
            m_addr  <= wb_addr;
            m_wdata <= wb_data;
            cnt     <= '0;
          end else if (req_rd) begin
            state  <= RD;
            m_req  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= raddr;
            cnt    <= '0;
          end
        end
        default: begin
          if (m_ack || tmo) begin
            state <= IDLE;
            m_req <= 1'b0;
            if (state == RD) begin
              rdata <= m_ack ? m_rdata : RD_ERR_DATA;
              rrdy  <= 1'b1;
            end
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_r408_dbus_bridge.sv
// tb_r408_dbus_bridge: randomized self-checking bench with a memory-consistency reference model
module tb_r408_dbus_bridge;
  logic clk = 1'b0, rst;
  logic [23:0] raddr, waddr, m_addr;
  logic [7:0] rdata, wdata, m_wdata, m_rdata;
  logic read, rrdy, write, wrdy, m_req, m_we, m_ack, err_clr, bus_err;
  always #5 clk = ~clk;
  r408_dbus_bridge #(.TMO_W(4)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .read(read), .rdata(rdata), .rrdy(rrdy),
    .waddr(waddr), .wdata(wdata), .write(write), .wrdy(wrdy),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err_clr(err_clr), .bus_err(bus_err)
  );
  int n_cmp = 0, n_bad = 0;
  int ack_delay = 0, rd_cnt = 0, last_len = 0;
  bit resp_off = 0;
  logic [31:0] exp_wq[$];
  logic [7:0] dev[int];
  logic [7:0] mdl[int];
  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] dflt(int a);
    return 8'(a) ^ 8'h5A;
  endfunction
  function automatic logic [7:0] dval(int a);
    return dev.exists(a) ? dev[a] : dflt(a);
  endfunction
  function automatic logic [7:0] mexp(int a);
    return mdl.exists(a) ? mdl[a] : dflt(a);
  endfunction
  // memory device: acks after ack_delay wait cycles, logs writes, tracks request length
  initial begin
    int len, wcnt;
    logic [39:0] snap;
    logic [31:0] e;
    bit prev_req;
    len = 0; wcnt = 0; snap = '0; prev_req = 0;
    m_ack = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      m_ack = 0;
      if (m_req === 1'b1) begin
        if (!prev_req) begin
          len = 1; wcnt = 0; snap = {7'b0, m_we, m_addr, m_wdata};
          if (!m_we) rd_cnt++;
        end else len++;
        if (!resp_off && wcnt >= ack_delay) begin
          m_ack = 1;
          chk("req_stable", {7'b0, m_we, m_addr, m_wdata}, snap);
          if (m_we) begin
            dev[int'(m_addr)] = m_wdata;
            if (exp_wq.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_write: got %0h expected none", {m_addr, m_wdata});
            end else begin
              e = exp_wq.pop_front();
              chk("mem_write", {m_addr, m_wdata}, e);
            end
          end else m_rdata = dval(int'(m_addr));
        end else wcnt++;
      end else if (prev_req) last_len = len;
      prev_req = (m_req === 1'b1);
    end
  end
  task automatic do_write(input logic [23:0] a, input logic [7:0] d, output int lat);
    waddr = a; wdata = d; write = 1; lat = 0;
    do begin @(negedge clk); lat++; end while (!wrdy && lat < 200);
    write = 0;
    chk("wrdy_seen", wrdy, 1);
    mdl[int'(a)] = d;
    exp_wq.push_back({a, d});
  endtask
  task automatic do_read(input logic [23:0] a, output logic [7:0] d, output int lat);
    raddr = a; read = 1; lat = 0;
    do begin @(negedge clk); lat++; end while (!rrdy && lat < 200);
    read = 0;
    chk("rrdy_seen", rrdy, 1);
    d = rdata;
  endtask
  task automatic rd_chk(input logic [23:0] a);
    logic [7:0] d;
    int lat;
    do_read(a, d, lat);
    chk("rand_rdata", d, mexp(int'(a)));
  endtask
  task automatic wait_idle();
    int i = 0;
    while ((m_req || exp_wq.size() != 0) && i < 200) begin @(negedge clk); i++; end
    chk("idle_wq", exp_wq.size(), 0);
    @(negedge clk);
  endtask
  initial begin
    int lat, l1, l2, rc, pulses;
    logic [7:0] d;
    logic [23:0] a, b;
    rst = 1; read = 0; write = 0; raddr = 0; waddr = 0; wdata = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_core", {rrdy, wrdy, rdata}, 0);
    chk("rst_mem", {m_req, m_we, m_addr, m_wdata}, 0);
    chk("rst_err", bus_err, 0);
    rst = 0;
    @(negedge clk);
    // posted write, ack after two wait cycles
    ack_delay = 2;
    do_write(24'h001234, 8'hA5, lat);
    chk("wr_lat", lat, 1);
    wait_idle();
    chk("wr_req_len", last_len, 3);
    chk("wr_dev", dev[32'h1234], 8'hA5);
    // forward from buffer before drain
    ack_delay = 1;
    rc = rd_cnt;
    do_write(24'h000010, 8'h3C, lat);
    do_read(24'h000010, d, lat);
    chk("fwd_data", d, 8'h3C);
    chk("fwd_lat", lat, 1);
    wait_idle();
    chk("fwd_nobus", rd_cnt, rc);
    chk("fwd_drain", dev[32'h10], 8'h3C);
    // minimum-latency read
    dev[32'h20] = 8'h5A; mdl[32'h20] = 8'h5A;
    ack_delay = 0;
    do_read(24'h000020, d, lat);
    chk("rd_data", d, 8'h5A);
    chk("rd_lat", lat, 2);
    wait_idle();
    // read timeout
    resp_off = 1;
    do_read(24'h000040, d, lat);
    chk("tmo_rdata", d, 8'hFF);
    chk("tmo_lat", lat, 16);
    chk("tmo_err", bus_err, 1);
    @(negedge clk);
    chk("tmo_len", last_len, 15);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("err_clr", bus_err, 0);
    // write timeout with err_clr held: set wins, then clears
    err_clr = 1;
    do_write(24'h000050, 8'h11, lat);
    exp_wq.delete();
    mdl.delete(32'h50);
    for (int i = 0; i < 50 && !m_req; i++) @(negedge clk);
    for (int i = 0; i < 50 && m_req; i++) @(negedge clk);
    chk("wtmo_drop", m_req, 0);
    chk("set_wins", bus_err, 1);
    @(negedge clk);
    chk("clr_after", bus_err, 0);
    err_clr = 0;
    resp_off = 0;
    do_write(24'h000051, 8'h22, lat);
    chk("wtmo_empty", lat, 1);
    wait_idle();
    // back-to-back writes
    ack_delay = 3;
    do_write(24'h000060, 8'h01, l1);
    do_write(24'h000061, 8'h02, l2);
    chk("b2b_lat1", l1, 1);
    chk("b2b_lat2", l2, 6);
    wait_idle();
    chk("b2b_dev", {dev[32'h60], dev[32'h61]}, 16'h0102);
    // reset mid-read
    resp_off = 1;
    raddr = 24'h000070; read = 1;
    repeat (3) @(negedge clk);
    chk("mid_rd_req", m_req, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_core", {rrdy, wrdy, rdata}, 0);
    chk("rst_mid_mem", {m_req, m_we, m_addr, m_wdata}, 0);
    chk("rst_mid_err", bus_err, 0);
    read = 0; rst = 0; resp_off = 0;
    pulses = 0;
    repeat (5) begin @(negedge clk); pulses += int'(rrdy); end
    chk("rst_no_rrdy", pulses, 0);
    // randomized mix, including a write captured while a read is on the bus
    for (int n = 0; n < 150; n++) begin
      ack_delay = $urandom_range(0, 5);
      a = 24'h10 + 24'($urandom_range(0, 3));
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: do_write(a, d, lat);
        1: rd_chk(a);
        default: begin
          b = 24'h10 + ((a - 24'h10 + 24'($urandom_range(1, 3))) % 4);
          fork
            do_write(a, d, l1);
            rd_chk(b);
          join
        end
      endcase
    end
    wait_idle();
    for (int i = 16; i < 20; i++) chk("final_mem", dev[i], mdl[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
